fir_mac_datapath: RTL and testbench

Time-multiplexed FIR arithmetic engine. It consumes the tap-phase stream from the tap counter (current_count, phase_min) and a coefficient read in the same cycle. It stores input samples in a circular delay line and performs one multiply-accumulate per tap. It emits one full-precision filter output per completed phase of NUMBER_OF_TAPS counts.

---
 rtl/fir_pkg.sv | 11 +
 rtl/fir_sample_buffer.sv | 35 +++
 rtl/fir_mac_datapath.sv | 77 +++++++
 tb/tb_fir_mac_datapath.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and width-derivation helpers for the FIR engine
package fir_pkg;
    localparam int INPUT_WIDTH_D = 16;
    localparam int COEFF_WIDTH_D = 16;
    function automatic int counter_bits(input int n);
        return $clog2(n);
    endfunction
    function automatic int acc_width(input int iw, input int cw, input int n);
        return iw + cw + counter_bits(n);
    endfunction
endpackage

// File: rtl/fir_sample_buffer.sv
// fir_sample_buffer: circular sample delay line with modular tap addressing
module fir_sample_buffer
    import fir_pkg::*;
#(
    parameter int N = 64,
    parameter int W = INPUT_WIDTH_D,
    localparam int CB = counter_bits(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic signed [W-1:0] wdata,
    input  logic [CB-1:0]       tap,
    output logic signed [W-1:0] rdata,
    output logic [CB-1:0]       head
);
    logic signed [W-1:0] mem [N];
    logic [CB-1:0] next_head;
    logic [CB-1:0] rd_addr;

    assign next_head = (head == CB'(N-1)) ? '0 : head + 1'b1;
    assign rd_addr = CB'({1'b0, head} + ((head >= tap) ? '0 : (CB+1)'(N)) - {1'b0, tap});
    assign rdata = mem[rd_addr];

    // newest sample lands one slot past the previous head; reset empties the history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= CB'(N-1);
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (we) begin
            head <= next_head;
            mem[next_head] <= wdata;
        end
    end
endmodule

// File: rtl/fir_mac_datapath.sv
// fir_mac_datapath: time-multiplexed FIR multiply-accumulate engine, one tap per enabled cycle
module fir_mac_datapath
    import fir_pkg::*;
#(
    parameter int NUMBER_OF_TAPS = 64,
    parameter int INPUT_WIDTH = INPUT_WIDTH_D,
    parameter int COEFF_WIDTH = COEFF_WIDTH_D,
    localparam int COUNTER_BITS = counter_bits(NUMBER_OF_TAPS),
    localparam int ACC_WIDTH = acc_width(INPUT_WIDTH, COEFF_WIDTH, NUMBER_OF_TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_enable,
    input  logic [COUNTER_BITS-1:0]       current_count,
    input  logic                          phase_min,
    input  logic signed [INPUT_WIDTH-1:0] filter_in,
    input  logic signed [COEFF_WIDTH-1:0] coeff_in,
    output logic signed [ACC_WIDTH-1:0]   filter_out,
    output logic                          filter_out_valid
);
    localparam int PROD_WIDTH = INPUT_WIDTH + COEFF_WIDTH;

    logic signed [INPUT_WIDTH-1:0] tap_sample;
    logic signed [INPUT_WIDTH-1:0] sample;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic first;
    logic last;
    logic s1_valid;
    logic primed;

    fir_sample_buffer #(.N(NUMBER_OF_TAPS), .W(INPUT_WIDTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (clk_enable && phase_min),
        .wdata (filter_in),
        .tap   (current_count),
        .rdata (tap_sample),
        .head  ()
    );

    assign sample = (current_count == '0) ? filter_in : tap_sample;
    assign prod_ext = ACC_WIDTH'(prod);

    // stage 1: product of the current tap plus phase-boundary markers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
            first <= 1'b0;
            last <= 1'b0;
            s1_valid <= 1'b0;
            primed <= 1'b0;
        end else if (clk_enable) begin
            prod <= PROD_WIDTH'(sample) * PROD_WIDTH'(coeff_in);
            first <= phase_min;
            last <= (current_count == COUNTER_BITS'(NUMBER_OF_TAPS-1)) && (primed || phase_min);
            s1_valid <= 1'b1;
            if (phase_min) primed <= 1'b1;
        end
    end

    // stage 2: running sum, published with a one-cycle pulse on the final tap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            filter_out <= '0;
            filter_out_valid <= 1'b0;
        end else begin
            filter_out_valid <= clk_enable && s1_valid && last;
            if (clk_enable && s1_valid) begin
                acc <= first ? prod_ext : acc + prod_ext;
                if (last) filter_out <= (first ? '0 : acc) + prod_ext;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_datapath.sv
// tb_fir_mac_datapath: scoreboard bench driving three filter lengths (4, 64, 5)
module tb_fir_mac_datapath;
    typedef struct { int g; longint v; int due; } exp_t;

    logic clk;
    logic rst;
    logic [2:0] en;
    logic [7:0] cnt [3];
    logic pm [3];
    logic signed [15:0] din [3];
    logic signed [15:0] coef [3];
    logic [2:0] vld;
    logic signed [33:0] o0;
    logic signed [37:0] o1;
    logic signed [34:0] o2;
    logic signed [63:0] outv [3];

    int total = 0;
    int bad = 0;
    int nt [3] = '{4, 64, 5};
    int h [3][64];
    longint hist [3][64];
    bit primed [3];
    int ecnt [3];
    longint seen [3][16];
    int nseen [3];
    longint last_v [3];
    exp_t sb [$];
    longint want_imp [6] = '{100, 200, 300, 400, 0, 0};
    longint want_ramp [7] = '{1, 3, 6, 10, 15, 20, 25};

    fir_mac_datapath #(.NUMBER_OF_TAPS(4)) u0 (
        .clk(clk), .rst(rst), .clk_enable(en[0]), .current_count(cnt[0][1:0]),
        .phase_min(pm[0]), .filter_in(din[0]), .coeff_in(coef[0]),
        .filter_out(o0), .filter_out_valid(vld[0]));
    fir_mac_datapath #(.NUMBER_OF_TAPS(64)) u1 (
        .clk(clk), .rst(rst), .clk_enable(en[1]), .current_count(cnt[1][5:0]),
        .phase_min(pm[1]), .filter_in(din[1]), .coeff_in(coef[1]),
        .filter_out(o1), .filter_out_valid(vld[1]));
    fir_mac_datapath #(.NUMBER_OF_TAPS(5)) u2 (
        .clk(clk), .rst(rst), .clk_enable(en[2]), .current_count(cnt[2][2:0]),
        .phase_min(pm[2]), .filter_in(din[2]), .coeff_in(coef[2]),
        .filter_out(o2), .filter_out_valid(vld[2]));

    assign outv[0] = 64'(o0);
    assign outv[1] = 64'(o1);
    assign outv[2] = 64'(o2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a new sample period may only start at tap 0
    always @(posedge clk)
        for (int g = 0; g < 3; g++)
            if (!rst && en[g]) assert (!pm[g] || cnt[g] == 8'd0)
                else $error("phase_min at count %0d on lane %0d", cnt[g], g);

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic refresh(input int g);
        pm[g] = (cnt[g] == 8'd0);
        coef[g] = 16'(h[g][cnt[g]]);
    endtask

    task automatic set_coefs(input int g, input int v);
        for (int k = 0; k < 64; k++) h[g][k] = v;
        refresh(g);
    endtask

    task automatic clear_model();
        for (int g = 0; g < 3; g++) begin
            primed[g] = 1'b0;
            for (int k = 0; k < 64; k++) hist[g][k] = 0;
        end
        sb.delete();
    endtask

    task automatic cycle();
        longint y;
        int idx;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            if (!rst && en[g]) begin
                ecnt[g]++;
                if (pm[g]) begin
                    for (int k = 63; k > 0; k--) hist[g][k] = hist[g][k-1];
                    hist[g][0] = din[g];
                    primed[g] = 1'b1;
                end
                if (cnt[g] == 8'(nt[g] - 1) && primed[g]) begin
                    y = 0;
                    for (int k = 0; k < nt[g]; k++) y += longint'(h[g][k]) * hist[g][k];
                    sb.push_back('{g, y, ecnt[g] + 1});
                end
                cnt[g] = (cnt[g] == 8'(nt[g] - 1)) ? 8'd0 : cnt[g] + 8'd1;
            end
            refresh(g);
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
                if (sb[i].g == g) begin
                    idx = i;
                    break;
                end
            if (vld[g]) begin
                if (idx < 0) check($sformatf("spurious_valid%0d", g), 64'(vld[g]), 0);
                else begin
                    check($sformatf("y%0d", g), outv[g], sb[idx].v);
                    check($sformatf("latency%0d", g), ecnt[g], sb[idx].due);
                    last_v[g] = outv[g];
                    if (nseen[g] < 16) begin
                        seen[g][nseen[g]] = outv[g];
                        nseen[g]++;
                    end
                    sb.delete(idx);
                end
            end else if (idx >= 0 && ecnt[g] >= sb[idx].due) begin
                check($sformatf("missing_valid%0d", g), 64'(vld[g]), 1);
                sb.delete(idx);
            end
        end
    endtask

    task automatic reset_async(input int ncyc);
        #3;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_out%0d", g), outv[g], 0);
            check($sformatf("rst_vld%0d", g), 64'(vld[g]), 0);
        end
        clear_model();
        repeat (ncyc) begin
            cycle();
            check("rst_hold_out0", outv[0], 0);
        end
        rst = 1'b0;
    endtask

    task automatic run_phase(input int g, input logic signed [15:0] x, input int stall_at = -1, input int stall_len = 0);
        din[g] = x;
        for (int k = 0; k < nt[g]; k++) begin
            if (k == stall_at) begin
                en[g] = 1'b0;
                repeat (stall_len) cycle();
                en[g] = 1'b1;
            end
            cycle();
        end
    endtask

    initial begin
        rst = 1'b0;
        en = '0;
        for (int g = 0; g < 3; g++) begin
            cnt[g] = 8'd0;
            din[g] = '0;
            ecnt[g] = 0;
            nseen[g] = 0;
            last_v[g] = 0;
            set_coefs(g, 0);
        end
        clear_model();
        reset_async(3);

        for (int k = 0; k < 4; k++) h[0][k] = k + 1;
        refresh(0);
        en[0] = 1'b1;
        run_phase(0, 16'sd100);
        repeat (5) run_phase(0, 16'sd0);
        cycle();
        en[0] = 1'b0;
        repeat (3) cycle();
        check("impulse_count", nseen[0], 6);
        for (int i = 0; i < 6; i++) check($sformatf("impulse[%0d]", i), seen[0][i], want_imp[i]);

        en[0] = 1'b1;
        while (cnt[0] != 8'd0) cycle();
        run_phase(0, 16'sd100);
        din[0] = 16'sd55;
        repeat (2) cycle();
        reset_async(3);
        nseen[0] = 0;
        while (cnt[0] != 8'd0) cycle();
        check("midreset_no_valid", nseen[0], 0);
        run_phase(0, 16'sd7);
        run_phase(0, 16'sd0);
        cycle();
        en[0] = 1'b0;
        repeat (2) cycle();
        check("midreset_count", nseen[0], 2);
        check("midreset_y0", seen[0][0], 7);
        check("midreset_y1", seen[0][1], 14);

        set_coefs(1, 32767);
        en[1] = 1'b1;
        for (int p = 0; p < 64; p++) run_phase(1, 16'sd32767, (p == 3) ? 17 : -1, 5);
        set_coefs(1, -32768);
        run_phase(1, -16'sd32768);
        check("max_pos", last_v[1], 64'sd68715282496);
        for (int p = 0; p < 63; p++) run_phase(1, -16'sd32768, (p == 20) ? 17 : -1, 5);
        cycle();
        en[1] = 1'b0;
        repeat (2) cycle();
        check("max_neg", last_v[1], 64'sd68719476736);

        set_coefs(2, 1);
        en[2] = 1'b1;
        for (int i = 1; i <= 7; i++) run_phase(2, 16'(i));
        cycle();
        en[2] = 1'b0;
        repeat (3) cycle();
        check("ramp_count", nseen[2], 7);
        for (int i = 0; i < 7; i++) check($sformatf("ramp[%0d]", i), seen[2][i], want_ramp[i]);

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
